// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// FSM state type, slice width and op encodings.
package addsub_pkg;
  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/nibble_addsub.sv
// Combinational 4-bit add/subtract slice: four ripple bit cells whose
// carry (add) or borrow (subtract) chain is selected by op.
module nibble_addsub
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c,
  input  logic                op,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  always_comb begin
    logic [NIBBLE_W:0] ch;
    ch    = '0;
    s     = '0;
    ch[0] = c;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ ch[i];
      // Borrow chain propagates directly; no inversion of b is used.
      if (op == OP_SUB)
        ch[i+1] = (~a[i] & b[i]) | (~a[i] & ch[i]) | (b[i] & ch[i]);
      else
        ch[i+1] = (a[i] & b[i]) | (ch[i] & (a[i] ^ b[i]));
    end
    co = ch[NIBBLE_W];
  end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// WIDTH-bit add/subtract sequencer iterating one nibble slice LSB-first.
// Optional zero/ovf result flags are built when ADDSUB_FLAGS_EN is defined.
module addsub_seq_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
`ifdef ADDSUB_FLAGS_EN
  output logic             zero,
  output logic             ovf,
`endif
  output state_e           fsm_state
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_e               state, state_next;
  logic [WIDTH-1:0]     a_q, b_q, res_q, res_fin;
  logic                 op_q, carry_q, cout_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NIBBLE_W-1:0]  a_nib, b_nib, s_nib;
  logic                 co_nib;

  // Handshake: a transfer happens on a rising edge where valid and ready
  // are both high; ready/valid here are decoded from state only, so no
  // input reaches an output within the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN:  if (cnt_q == LAST) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign a_nib = a_q[cnt_q*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[cnt_q*NIBBLE_W +: NIBBLE_W];

  nibble_addsub u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .c  (carry_q),
    .op (op_q),
    .s  (s_nib),
    .co (co_nib)
  );

  // Result with the current nibble merged in; on the last RUN edge this is
  // the final value the flags are derived from.
  always_comb begin
    res_fin = res_q;
    res_fin[cnt_q*NIBBLE_W +: NIBBLE_W] = s_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (state == IDLE && in_valid) begin
      a_q     <= a;
      b_q     <= b;
      op_q    <= op;
      carry_q <= cin;
      cnt_q   <= '0;
    end else if (state == RUN) begin
      res_q   <= res_fin;
      carry_q <= co_nib;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (cnt_q == LAST) cout_q <= co_nib;
    end
  end

`ifdef ADDSUB_FLAGS_EN
  logic zero_q, ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == RUN && cnt_q == LAST) begin
      zero_q <= (res_fin == '0);
      if (op_q == OP_ADD)
        ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_fin[WIDTH-1] != a_q[WIDTH-1]);
      else
        ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_fin[WIDTH-1] != a_q[WIDTH-1]);
    end
  end

  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

  assign res       = res_q;
  assign cout      = cout_q;
  assign fsm_state = state;

endmodule
